// File: rtl/serial_add_sequencer_pkg.sv
// ============================================================================
// Module   : serial_add_sequencer_pkg
// Brief    : FSM state encoding and sizing helper for the bit-serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_add_sequencer_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Bit counter needs at least one bit even when WIDTH is 1.
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_sequencer_if.sv
// ============================================================================
// Module   : serial_add_sequencer_if
// Brief    : Start/busy/done request bus between a requester and the adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_add_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (output start, a, b, cin, input  busy, done, sum, cout);
   modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

`default_nettype wire

// File: rtl/full_adder_1b.sv
// ============================================================================
// Module   : full_adder_1b
// Brief    : One-bit full adder from two half adders and an OR gate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_1b (
   input  wire logic a,
   input  wire logic b,
   input  wire logic ci,
   output logic      s,
   output logic      co
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   half_adder u_ha0 (.a(a),    .b(b),  .s(w_s1), .c(w_c1));
   half_adder u_ha1 (.a(w_s1), .b(ci), .s(s),    .c(w_c2));

   assign co = w_c1 | w_c2;
endmodule

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// Module   : half_adder
// Brief    : One-bit half adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module half_adder (
   input  wire logic a,
   input  wire logic b,
   output logic      s,
   output logic      c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module   : serial_add_sequencer
// Brief    : Bit-serial WIDTH-bit adder sharing one full adder over all bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_sequencer
   import serial_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   serial_add_sequencer_if.slave bus
);
   localparam int              c_IDX_W = idx_width(WIDTH);
   localparam int              c_RES_W = (WIDTH > 1) ? WIDTH - 1 : 1;
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_carry;
   logic [c_IDX_W-1:0] r_idx;
   logic [c_RES_W-1:0] r_res;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               w_fa_s;
   logic               w_fa_co;
   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_shift;
   logic [c_RES_W-1:0] w_res_next;

   full_adder_1b u_fa (
      .a (r_a[0]),
      .b (r_b[0]),
      .ci(r_carry),
      .s (w_fa_s),
      .co(w_fa_co)
   );

   assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_idx == c_LAST);

   // Only the WIDTH-1 earlier sum bits are stored; the current bit joins at the MSB.
   if (WIDTH == 1) begin : g_w1
      assign w_res_shift = w_fa_s;
      assign w_res_next  = '0;
   end else begin : g_wn
      assign w_res_shift = {w_fa_s, r_res};
      assign w_res_next  = w_res_shift[WIDTH-1:1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
         S_RUN:   w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (r_state == S_RUN);
      bus.done = (r_state == S_DONE);
      bus.sum  = r_sum;
      bus.cout = r_cout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_carry <= bus.cin;
         r_idx   <= '0;
         r_res   <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_fa_co;
         r_res   <= w_res_next;
         if (w_last) begin
            r_sum  <= w_res_shift;
            r_cout <= w_fa_co;
         end else begin
            r_idx  <= r_idx + c_IDX_W'(1);
         end
      end
   end

endmodule

`default_nettype wire
